// File: rtl/svc_rv_pkg.sv
// Shared RV core definitions: M-extension divide op encoding and divider FSM states.
// Optional divider feature macro: SVC_RV_DIV_EARLY_EXIT_EN (see svc_rv_div_mc).
package svc_rv_pkg;

    // funct3[1:0] of the M-extension divide/remainder encodings
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CHK  = 2'b01,
        ST_CALC = 2'b10,
        ST_ADJ  = 2'b11
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/svc_rv_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module svc_rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quot_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quot_out
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    always_comb begin
        shifted  = {rem_in, quot_in[XLEN-1]};
        fits     = (shifted >= {2'b00, divisor});
        diff     = shifted[XLEN:0] - {1'b0, divisor};
        rem_out  = fits ? diff : shifted[XLEN:0];
        quot_out = {quot_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/svc_rv_div_mc.sv
// Multi-cycle RV32/64 M-extension divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define SVC_RV_DIV_EARLY_EXIT_EN to finish in CHK when |dividend| < |divisor|.
module svc_rv_div_mc
    import svc_rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state, state_nxt;

    div_op_t           op_lat;
    logic [XLEN-1:0]   dvd_orig;
    logic [XLEN-1:0]   dvs_orig;
    logic [XLEN-1:0]   dvs_mag;
    logic [XLEN-1:0]   quot;
    logic [XLEN:0]     rem;
    logic              neg_quot;
    logic              neg_rem;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              done_nxt;
    logic [XLEN-1:0]   result_nxt;

    logic              accept;
    logic              in_signed;
    logic              dvd_neg;
    logic              dvs_neg;
    logic [XLEN-1:0]   dvd_abs;
    logic [XLEN-1:0]   dvs_abs;

    logic              div_zero;
    logic              overflow;
    logic              early;
    logic              special;
    logic [XLEN-1:0]   special_val;
    logic [XLEN-1:0]   quot_adj;
    logic [XLEN-1:0]   rem_adj;

    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quot;

    assign busy   = (state != ST_IDLE);
    assign accept = start && !busy && !kill;

    // Operand conditioning at accept: signed ops work on magnitudes
    always_comb begin
        in_signed = op_is_signed(div_op_t'(op));
        dvd_neg   = in_signed && dividend[XLEN-1];
        dvs_neg   = in_signed && divisor[XLEN-1];
        dvd_abs   = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_abs   = dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    svc_rv_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_in  (rem),
        .quot_in (quot),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .quot_out(step_quot)
    );

    // Special-case detection in CHK; quot still holds |dividend| there
    always_comb begin
        div_zero = (dvs_mag == '0);
        overflow = op_is_signed(op_lat) && (dvd_orig == INT_MIN) && (dvs_orig == '1);
`ifdef SVC_RV_DIV_EARLY_EXIT_EN
        early    = (quot < dvs_mag);
`else
        early    = 1'b0;
`endif
        special     = div_zero || overflow || early;
        special_val = '0;
        if (div_zero) begin
            special_val = op_is_rem(op_lat) ? dvd_orig : '1;
        end else if (overflow) begin
            special_val = op_is_rem(op_lat) ? '0 : dvd_orig;
        end else if (early) begin
            special_val = op_is_rem(op_lat) ? dvd_orig : '0;
        end
    end

    always_comb begin
        quot_adj = neg_quot ? (~quot + 1'b1) : quot;
        rem_adj  = neg_rem ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        result_nxt = result;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (special) begin
                    state_nxt  = ST_IDLE;
                    done_nxt   = 1'b1;
                    result_nxt = special_val;
                end else begin
                    state_nxt = ST_CALC;
                    cnt_nxt   = CNT_W'(XLEN);
                end
            end
            ST_CALC: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_ADJ;
                end
            end
            ST_ADJ: begin
                state_nxt  = ST_IDLE;
                done_nxt   = 1'b1;
                result_nxt = op_is_rem(op_lat) ? rem_adj : quot_adj;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Flush wins over everything, including a same-cycle start
        if (kill) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            done_nxt   = 1'b0;
            result_nxt = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done   <= done_nxt;
            result <= result_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_lat   <= OP_DIV;
            dvd_orig <= '0;
            dvs_orig <= '0;
            dvs_mag  <= '0;
            quot     <= '0;
            rem      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (accept) begin
            op_lat   <= div_op_t'(op);
            dvd_orig <= dividend;
            dvs_orig <= divisor;
            dvs_mag  <= dvs_abs;
            quot     <= dvd_abs;
            rem      <= '0;
            neg_quot <= dvd_neg ^ dvs_neg;
            neg_rem  <= dvd_neg;
        end else if (state == ST_CALC && !kill) begin
            quot <= step_quot;
            rem  <= step_rem;
        end
    end

endmodule
